// File: rtl/instr_assembler_pkg.sv
// Shared MIPS encoding constants, request class codes and assembler state encoding.
// Also used by the control decoder and its benches.
package instr_assembler_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    CLS_R    = 4'd0,
    CLS_ADDI = 4'd1,
    CLS_ANDI = 4'd2,
    CLS_ORI  = 4'd3,
    CLS_XORI = 4'd4,
    CLS_LW   = 4'd5,
    CLS_SW   = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_LUI  = 4'd8,
    CLS_J    = 4'd9
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] j_word(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Request and instruction-memory write bus of the assembler.
// master = request source, slave = assembler.
interface instr_assembler_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_class;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              req_last;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output req_valid, req_class, req_rs, req_rt, req_rd, req_funct,
           req_imm, req_target, req_last,
    input  req_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  req_valid, req_class, req_rs, req_rt, req_rd, req_funct,
           req_imm, req_target, req_last,
    output req_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_assembler_encode.sv
// Combinational encoder: request class plus fields -> 32-bit MIPS word.
// valid is low for unsupported classes (10-15); the word is then zero.
module instr_encode
  import instr_assembler_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  always_comb begin
    word  = 32'd0;
    valid = 1'b1;
    case (cls)
      CLS_R:    word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
      CLS_ADDI: word = {OP_ADDI, rs, rt, imm};
      CLS_ANDI: word = {OP_ANDI, rs, rt, imm};
      CLS_ORI:  word = {OP_ORI, rs, rt, imm};
      CLS_XORI: word = {OP_XORI, rs, rt, imm};
      CLS_LW:   word = {OP_LW, rs, rt, imm};
      CLS_SW:   word = {OP_SW, rs, rt, imm};
      CLS_BEQ:  word = {OP_BEQ, rs, rt, imm};
      CLS_LUI:  word = {OP_LUI, 5'd0, rt, imm};
      CLS_J:    word = j_word(target);
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Streams encoded instructions into instruction memory from word address 0.
// Define ASSEMBLER_HALT_EN to append a j-to-self halt word after every program.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_assembler_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef ASSEMBLER_HALT_EN
  localparam bit HALT_EN = 1'b1;
  localparam int CAP     = DEPTH - 1;
`else
  localparam bit HALT_EN = 1'b0;
  localparam int CAP     = DEPTH;
`endif
  localparam logic [ADDR_W:0] CAP_C   = (ADDR_W + 1)'(CAP);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic              fin_q, fin_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;

  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              ready;
  logic              accept;

  instr_encode u_encode (
    .cls    (bus.req_class),
    .rs     (bus.req_rs),
    .rt     (bus.req_rt),
    .rd     (bus.req_rd),
    .funct  (bus.req_funct),
    .imm    (bus.req_imm),
    .target (bus.req_target),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  assign accept = bus.req_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      err_q      <= 2'b00;
      fin_q      <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      fin_q      <= fin_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  // fin_q marks the write cycle of the closing request; the program ends after it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (fin_q) state_d = HALT_EN ? ST_HALT : ST_DONE;
      ST_HALT:          state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_RUN) && !fin_q && (count_q != CAP_C);
    busy  = (state_q == ST_RUN) || (state_q == ST_HALT);
    done  = (state_q == ST_DONE);
  end

  // The word count doubles as the write pointer: both start at 0 and step together.
  always_comb begin
    count_d    = count_q;
    err_d      = err_q;
    fin_d      = fin_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
      count_d = '0;
      err_d   = 2'b00;
      fin_d   = 1'b0;
    end

    if (state_q == ST_RUN) begin
      if (accept) begin
        if (enc_valid) begin
          im_we_d    = 1'b1;
          im_addr_d  = count_q[ADDR_W-1:0];
          im_wdata_d = enc_word;
          count_d    = count_q + CNT_ONE;
          if (count_d == CAP_C) begin
            err_d[1] = 1'b1;
            fin_d    = 1'b1;
          end
        end else begin
          err_d[0] = 1'b1;
        end
        if (bus.req_last) fin_d = 1'b1;
      end
      if (fin_q) begin
        fin_d = 1'b0;
        if (HALT_EN) begin
          im_we_d    = 1'b1;
          im_addr_d  = count_q[ADDR_W-1:0];
          im_wdata_d = j_word(26'(count_q[ADDR_W-1:0]));
          count_d    = count_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign err           = err_q;
  assign count         = count_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench: a 256-word and a 4-word assembler checked every cycle
// against an arithmetic reference model, plus directed literal checks.
module tb_instr_assembler;

`ifdef ASSEMBLER_HALT_EN
  localparam int HALT = 1;
`else
  localparam int HALT = 0;
`endif

  localparam int PH_OFF      = 0;
  localparam int PH_OPEN     = 1;
  localparam int PH_CLOSING  = 2;
  localparam int PH_TRAILER  = 3;
  localparam int PH_FINISHED = 4;

  // Opcodes by class, as plain decimal numbers.
  localparam int unsigned OPC [10] = '{0, 8, 12, 13, 14, 35, 43, 4, 15, 2};

  typedef struct {
    logic        valid;
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } req_t;

  typedef struct {
    int          ready;
    int          we;
    int          addr;
    logic [31:0] data;
    int          busy;
    int          done;
    int          err;
    int          count;
  } obs_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } log_t;

  logic clk;
  logic rst_n;
  logic start_a;
  logic start_b;
  req_t drv [2];

  logic       busy_a, done_a, busy_b, done_b;
  logic [1:0] err_a, err_b;
  logic [8:0] count_a;
  logic [2:0] count_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  log_t log_a [$];
  log_t log_b [$];

  int          m_phase [2] = '{PH_OFF, PH_OFF};
  int          m_words [2] = '{0, 0};
  int          m_err   [2] = '{0, 0};
  int          m_we    [2] = '{0, 0};
  int          m_addr  [2] = '{0, 0};
  logic [31:0] m_data  [2] = '{32'd0, 32'd0};

  instr_assembler_if #(.ADDR_W(8)) ifa ();
  instr_assembler_if #(.ADDR_W(2)) ifb ();

  assign ifa.req_valid  = drv[0].valid;
  assign ifa.req_class  = drv[0].cls;
  assign ifa.req_rs     = drv[0].rs;
  assign ifa.req_rt     = drv[0].rt;
  assign ifa.req_rd     = drv[0].rd;
  assign ifa.req_funct  = drv[0].funct;
  assign ifa.req_imm    = drv[0].imm;
  assign ifa.req_target = drv[0].target;
  assign ifa.req_last   = drv[0].last;
  assign ifb.req_valid  = drv[1].valid;
  assign ifb.req_class  = drv[1].cls;
  assign ifb.req_rs     = drv[1].rs;
  assign ifb.req_rt     = drv[1].rt;
  assign ifb.req_rd     = drv[1].rd;
  assign ifb.req_funct  = drv[1].funct;
  assign ifb.req_imm    = drv[1].imm;
  assign ifb.req_target = drv[1].target;
  assign ifb.req_last   = drv[1].last;

  instr_assembler #(.ADDR_W(8)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .bus   (ifa.slave),
    .busy  (busy_a),
    .done  (done_a),
    .err   (err_a),
    .count (count_a)
  );

  instr_assembler #(.ADDR_W(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .bus   (ifb.slave),
    .busy  (busy_b),
    .done  (done_b),
    .err   (err_b),
    .count (count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached without finishing");
    $fatal(1, "[TB] watchdog");
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifa.im_we) log_a.push_back('{int'(ifa.im_addr), ifa.im_wdata, cyc});
    if (ifb.im_we) log_b.push_back('{int'(ifb.im_addr), ifb.im_wdata, cyc});
  end

  function automatic int cap_of(input int u);
    return ((u == 0) ? 256 : 4) - HALT;
  endfunction

  function automatic int model_ready(input int u);
    return (m_phase[u] == PH_OPEN && m_words[u] < cap_of(u)) ? 1 : 0;
  endfunction

  // Encode by weighted field sums rather than bit concatenation.
  function automatic logic [31:0] model_encode(input req_t r, output bit ok);
    longint unsigned w;
    ok = (r.cls <= 4'd9);
    if (!ok) return 32'd0;
    w = longint'(OPC[r.cls]) * 67108864;
    if (r.cls == 4'd0)
      w = w + longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048 + longint'(r.funct);
    else if (r.cls == 4'd9)
      w = w + longint'(r.target);
    else if (r.cls == 4'd8)
      w = w + longint'(r.rt) * 65536 + longint'(r.imm);
    else
      w = w + longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.imm);
    return w[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_phase[u] = PH_OFF;
        m_words[u] = 0;
        m_err[u]   = 0;
        m_we[u]    = 0;
        m_addr[u]  = 0;
        m_data[u]  = 32'd0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        int          rdy;
        bit          st;
        bit          ok;
        logic [31:0] w;
        rdy = model_ready(u);
        st  = (u == 0) ? start_a : start_b;
        m_we[u] = 0;
        case (m_phase[u])
          PH_OFF, PH_FINISHED: begin
            if (st) begin
              m_phase[u] = PH_OPEN;
              m_words[u] = 0;
              m_err[u]   = 0;
            end
          end
          PH_OPEN: begin
            if (drv[u].valid && rdy == 1) begin
              w = model_encode(drv[u], ok);
              if (ok) begin
                m_we[u]   = 1;
                m_addr[u] = m_words[u];
                m_data[u] = w;
                m_words[u]++;
                if (m_words[u] == cap_of(u)) begin
                  m_err[u]   = m_err[u] | 2;
                  m_phase[u] = PH_CLOSING;
                end
              end else begin
                m_err[u] = m_err[u] | 1;
              end
              if (drv[u].last) m_phase[u] = PH_CLOSING;
            end
          end
          PH_CLOSING: begin
            if (HALT == 1) begin
              m_we[u]    = 1;
              m_addr[u]  = m_words[u];
              m_data[u]  = 32'h0800_0000 + 32'(m_words[u]);
              m_words[u]++;
              m_phase[u] = PH_TRAILER;
            end else begin
              m_phase[u] = PH_FINISHED;
            end
          end
          default: m_phase[u] = PH_FINISHED;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic obs_t observe(input int u);
    obs_t o;
    if (u == 0) begin
      o = '{int'(ifa.req_ready), int'(ifa.im_we), int'(ifa.im_addr), ifa.im_wdata,
            int'(busy_a), int'(done_a), int'(err_a), int'(count_a)};
    end else begin
      o = '{int'(ifb.req_ready), int'(ifb.im_we), int'(ifb.im_addr), ifb.im_wdata,
            int'(busy_b), int'(done_b), int'(err_b), int'(count_b)};
    end
    return o;
  endfunction

  task automatic compareCycle();
    for (int u = 0; u < 2; u++) begin
      obs_t o;
      int   ph;
      o  = observe(u);
      ph = m_phase[u];
      checkOutput($sformatf("u%0d_req_ready", u), o.ready, model_ready(u));
      checkOutput($sformatf("u%0d_im_we", u), o.we, m_we[u]);
      checkOutput($sformatf("u%0d_busy", u), o.busy,
                  (ph == PH_OPEN || ph == PH_CLOSING || ph == PH_TRAILER) ? 1 : 0);
      checkOutput($sformatf("u%0d_done", u), o.done, (ph == PH_FINISHED) ? 1 : 0);
      checkOutput($sformatf("u%0d_err", u), o.err, m_err[u]);
      checkOutput($sformatf("u%0d_count", u), o.count, m_words[u]);
      if (m_we[u] == 1) begin
        checkOutput($sformatf("u%0d_im_addr", u), o.addr, m_addr[u]);
        checkOutput($sformatf("u%0d_im_wdata", u), o.data, m_data[u]);
      end
    end
  endtask

  task automatic startProgram(input int u);
    if (u == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Drives one request and holds it until accepted or max_wait cycles pass.
  task automatic applyStimulus(input int u, input int cls, input int rs, input int rt,
                               input int rd, input int funct, input int imm,
                               input int target, input bit last, input int max_wait,
                               output bit accepted);
    int rdy;
    drv[u] = '{1'b1, 4'(cls), 5'(rs), 5'(rt), 5'(rd), 6'(funct), 16'(imm), 26'(target), last};
    accepted = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      rdy = (u == 0) ? int'(ifa.req_ready) : int'(ifb.req_ready);
      @(posedge clk);
      if (rdy == 1) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) @(negedge clk);
    drv[u].valid = 1'b0;
  endtask

  task automatic checkWrite(input string name, input int u, input int idx,
                            input int exp_addr, input logic [31:0] exp_data);
    log_t e;
    int   n;
    n = (u == 0) ? log_a.size() : log_b.size();
    if (idx >= n) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: write #%0d missing, only %0d logged", name, idx, n);
      return;
    end
    e = (u == 0) ? log_a[idx] : log_b[idx];
    checkOutput({name, "_addr"}, e.addr, exp_addr);
    checkOutput({name, "_data"}, e.data, exp_data);
  endtask

  initial begin
    bit          acc;
    int          base;
    logic [31:0] exp_b [4];

    rst_n   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int u = 0; u < 2; u++) drv[u] = '{1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0};
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join_none

    @(negedge clk);
    checkOutput("reset_im_we", ifa.im_we, 0);
    checkOutput("reset_count", count_a, 0);
    checkOutput("reset_req_ready", ifa.req_ready, 0);
    checkOutput("reset_busy", busy_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single addi.
    startProgram(0);
    applyStimulus(0, 1, 0, 8, 0, 0, 5, 0, 1'b1, 4, acc);
    checkOutput("t1_accepted", acc, 1);
    checkOutput("t1_im_we", ifa.im_we, 1);
    checkOutput("t1_im_addr", ifa.im_addr, 0);
    checkOutput("t1_im_wdata", ifa.im_wdata, 32'h2008_0005);
    checkOutput("t1_count", count_a, 1);
    @(negedge clk); @(negedge clk);
    checkOutput("t1_done", done_a, 1);

    // Back-to-back R, sw, lui(last).
    base = log_a.size();
    startProgram(0);
    applyStimulus(0, 0, 8, 9, 10, 32'h20, 0, 0, 1'b0, 4, acc);
    applyStimulus(0, 6, 29, 31, 0, 0, 4, 0, 1'b0, 4, acc);
    applyStimulus(0, 8, 5, 1, 0, 0, 32'h1234, 0, 1'b1, 4, acc);
    @(negedge clk); @(negedge clk); #1;
    checkOutput("t2_writes", log_a.size() - base, 3 + HALT);
    checkWrite("t2_w0", 0, base, 0, 32'h0109_5020);
    checkWrite("t2_w1", 0, base + 1, 1, 32'hAFBF_0004);
    checkWrite("t2_w2", 0, base + 2, 2, 32'h3C01_1234);
    if (HALT == 1) checkWrite("t2_halt", 0, base + 3, 3, 32'h0800_0003);
    if (log_a.size() >= base + 3)
      checkOutput("t2_consecutive", log_a[base + 2].cyc - log_a[base].cyc, 2);
    checkOutput("t2_done", done_a, 1);
    checkOutput("t2_count", count_a, 3 + HALT);

    // beq then an unsupported class carrying last.
    base = log_a.size();
    startProgram(0);
    applyStimulus(0, 7, 1, 2, 0, 0, 32'hFFFF, 0, 1'b0, 4, acc);
    applyStimulus(0, 12, 3, 3, 3, 3, 3, 3, 1'b1, 4, acc);
    checkOutput("t3_bad_accepted", acc, 1);
    @(negedge clk); @(negedge clk); #1;
    checkOutput("t3_writes", log_a.size() - base, 1 + HALT);
    checkWrite("t3_w0", 0, base, 0, 32'h1022_FFFF);
    if (HALT == 1) checkWrite("t3_halt", 0, base + 1, 1, 32'h0800_0001);
    checkOutput("t3_err", err_a, 2'b01);
    checkOutput("t3_count", count_a, 1 + HALT);
    checkOutput("t3_done", done_a, 1);

    // Filling the 4-word memory.
    exp_b = '{32'h3401_0100, 32'h3422_0101, 32'h3443_0102,
              (HALT == 1) ? 32'h0800_0003 : 32'h3464_0103};
    base = log_b.size();
    startProgram(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 3, i, i + 1, 0, 0, 32'h100 + i, 0, 1'b0, 3, acc);
      checkOutput($sformatf("t4_accept%0d", i), acc, (i < 4 - HALT) ? 1 : 0);
    end
    #1;
    checkOutput("t4_writes", log_b.size() - base, 4);
    for (int i = 0; i < 4; i++) checkWrite($sformatf("t4_w%0d", i), 1, base + i, i, exp_b[i]);
    checkOutput("t4_err", err_b, 2'b10);
    checkOutput("t4_done", done_b, 1);
    checkOutput("t4_count", count_b, 4);
    checkOutput("t4_ready", ifb.req_ready, 0);

    // Reset during a write cycle, then restart.
    startProgram(0);
    applyStimulus(0, 2, 4, 5, 0, 0, 32'h00F0, 0, 1'b0, 4, acc);
    checkOutput("t5_im_we_before", ifa.im_we, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_im_we_reset", ifa.im_we, 0);
    checkOutput("t5_count_reset", count_a, 0);
    checkOutput("t5_busy_reset", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startProgram(0);
    applyStimulus(0, 4, 3, 4, 0, 0, 32'h00FF, 0, 1'b1, 4, acc);
    checkOutput("t5_im_addr", ifa.im_addr, 0);
    checkOutput("t5_im_wdata", ifa.im_wdata, 32'h3864_00FF);
    @(negedge clk); @(negedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
